// File: rtl/sc_pkg.sv
// Shared encodings, FSM state type and LFSR constants for the
// stochastic-computing multiply engine.
package sc_pkg;

   localparam logic [1:0] MODE_AND  = 2'b00;
   localparam logic [1:0] MODE_XNOR = 2'b01;
   localparam logic [1:0] MODE_ADD  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_FLUSH = 2'b10
   } state_e;

   // x^31 + x^28 + 1 maps to taps at bit 30 and bit 27 of a 31-bit register.
   localparam int LFSR_W  = 31;
   localparam int TAP_HI  = 30;
   localparam int TAP_LO  = 27;
   localparam int SEL_BIT = 15;

   localparam logic [LFSR_W-1:0] SEED_A = 31'h0000_0001;
   localparam logic [LFSR_W-1:0] SEED_B = 31'h2A5A_5A5A;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
   endfunction

endpackage

// File: rtl/sc_mult_engine_if.sv
// Handshake/operand bundle between a requester and sc_mult_engine.
interface sc_mult_engine_if #(
   parameter int PROB_W   = 4,
   parameter int LEN_LOG2 = 3
);
   logic                start;
   logic [1:0]          mode;
   logic [PROB_W-1:0]   prob_a;
   logic [PROB_W-1:0]   prob_b;
   logic                busy;
   logic                done;
   logic [LEN_LOG2:0]   result;
   logic                sn_out;

   modport master (
      output start, mode, prob_a, prob_b,
      input  busy, done, result, sn_out
   );

   modport slave (
      input  start, mode, prob_a, prob_b,
      output busy, done, result, sn_out
   );
endinterface

// File: rtl/sc_sng.sv
// Stochastic number generator: 31-bit Fibonacci LFSR with seed load and a
// comparator that turns a PROB_W-bit slice of the state into one stream bit.
module sc_sng
   import sc_pkg::*;
#(
   parameter int                PROB_W   = 4,
   parameter int                SLICE_LO = 0,
   parameter logic [LFSR_W-1:0] SEED     = SEED_A
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               en,
   input  logic [PROB_W-1:0]  prob,
   output logic [LFSR_W-1:0]  lfsr_q,
   output logic               sn_q
);

   logic [LFSR_W-1:0] lfsr_d;
   logic              sn_d;
   logic [PROB_W-1:0] slice_s;

   // Compare uses the pre-shift state, so the bit and the shift share one edge.
   always_comb begin
      slice_s = lfsr_q[SLICE_LO +: PROB_W];
      sn_d    = 1'b0;
      lfsr_d  = lfsr_q;
      if (en) begin
         sn_d = (slice_s < prob);
      end else begin
         sn_d = 1'b0;
      end
      if (load) begin
         lfsr_d = SEED;
      end else if (en) begin
         lfsr_d = lfsr_next(lfsr_q);
      end else begin
         lfsr_d = lfsr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
         sn_q   <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d;
         sn_q   <= sn_d;
      end
   end

endmodule

// File: rtl/sc_mult_engine.sv
// Stochastic multiply/scaled-add engine: two SNGs, a combine stage and a
// ones counter over an N-bit stream. Scaled add is built with SC_SCALED_ADD_EN.
module sc_mult_engine
   import sc_pkg::*;
#(
   parameter int PROB_W   = 4,
   parameter int LEN_LOG2 = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   sc_mult_engine_if.slave bus
);

   localparam logic [LEN_LOG2-1:0] LAST_RUN   = {LEN_LOG2{1'b1}};
   localparam logic [LEN_LOG2-1:0] LAST_FLUSH = LEN_LOG2'(1);

   state_e              state_q, state_d;
   logic [LEN_LOG2-1:0] step_q, step_d;
   logic                fin_q, fin_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [LEN_LOG2:0]   cnt_q, cnt_d;
   logic [LEN_LOG2:0]   result_q, result_d;
   logic                run_q, run_d;
   logic                sn_out_q, sn_out_d;
   logic [PROB_W-1:0]   pa_q, pa_d;
   logic [PROB_W-1:0]   pb_q, pb_d;
   logic                comb_s;
   logic                start_acc_s;
   logic                shift_s;
   logic                a_s, b_s;
   logic [LFSR_W-1:0]   lfsr_a_s, lfsr_b_s;
   logic                unused_lfsr_a_s;

`ifdef SC_SCALED_ADD_EN
   logic [1:0]          mode_q, mode_d;
   logic                sel_q, sel_d;
`else
   logic                mode_q, mode_d;
   logic                unused_sel_src_s;
`endif

   assign start_acc_s = (state_q == ST_IDLE) && bus.start;
   assign shift_s     = (state_q == ST_RUN);

   sc_sng #(
      .PROB_W   (PROB_W),
      .SLICE_LO (LFSR_W - PROB_W),
      .SEED     (SEED_A)
   ) u_sng_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (start_acc_s),
      .en     (shift_s),
      .prob   (pa_q),
      .lfsr_q (lfsr_a_s),
      .sn_q   (a_s)
   );

   sc_sng #(
      .PROB_W   (PROB_W),
      .SLICE_LO (0),
      .SEED     (SEED_B)
   ) u_sng_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (start_acc_s),
      .en     (shift_s),
      .prob   (pb_q),
      .lfsr_q (lfsr_b_s),
      .sn_q   (b_s)
   );

   assign unused_lfsr_a_s = ^lfsr_a_s;

   // FSM next state: N stream cycles in RUN, two drain cycles in FLUSH.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      fin_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_RUN;
               step_d  = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (step_q == LAST_RUN) begin
               state_d = ST_FLUSH;
               step_d  = '0;
            end else begin
               step_d  = step_q + LEN_LOG2'(1);
            end
         end
         ST_FLUSH: begin
            if (step_q == LAST_FLUSH) begin
               state_d = ST_IDLE;
               step_d  = '0;
               fin_d   = 1'b1;
            end else begin
               step_d  = step_q + LEN_LOG2'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            step_d  = '0;
         end
      endcase
   end

`ifdef SC_SCALED_ADD_EN
   // Combine SNG bits; 1x modes take A when the registered select is 1.
   always_comb begin
      mode_d = start_acc_s ? bus.mode : mode_q;
      sel_d  = shift_s ? lfsr_b_s[SEL_BIT] : 1'b0;
      comb_s = 1'b0;
      case (mode_q)
         MODE_AND:  comb_s = a_s & b_s;
         MODE_XNOR: comb_s = ~(a_s ^ b_s);
         default:   comb_s = sel_q ? a_s : b_s;
      endcase
   end
`else
   assign unused_sel_src_s = ^{lfsr_b_s, bus.mode[1]};

   // Combine SNG bits; only mode[0] is meaningful in this build.
   always_comb begin
      mode_d = start_acc_s ? bus.mode[0] : mode_q;
      comb_s = 1'b0;
      if (mode_q) begin
         comb_s = ~(a_s ^ b_s);
      end else begin
         comb_s = a_s & b_s;
      end
   end
`endif

   // Datapath: operand latch, stream gating, ones counter and result capture.
   always_comb begin
      pa_d     = start_acc_s ? bus.prob_a : pa_q;
      pb_d     = start_acc_s ? bus.prob_b : pb_q;
      run_d    = shift_s;
      sn_out_d = run_q ? comb_s : 1'b0;
      busy_d   = (state_d != ST_IDLE);
      done_d   = fin_q;
      result_d = fin_q ? cnt_q : result_q;
      if (start_acc_s) begin
         cnt_d = '0;
      end else if (state_q != ST_IDLE) begin
         cnt_d = cnt_q + (LEN_LOG2+1)'(sn_out_q);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         step_q   <= '0;
         fin_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         run_q    <= 1'b0;
         sn_out_q <= 1'b0;
         pa_q     <= '0;
         pb_q     <= '0;
         mode_q   <= '0;
`ifdef SC_SCALED_ADD_EN
         sel_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         fin_q    <= fin_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         run_q    <= run_d;
         sn_out_q <= sn_out_d;
         pa_q     <= pa_d;
         pb_q     <= pb_d;
         mode_q   <= mode_d;
`ifdef SC_SCALED_ADD_EN
         sel_q    <= sel_d;
`endif
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.sn_out = sn_out_q;

endmodule

// File: tb/tb_sc_mult_engine.sv
// Directed self-checking bench for sc_mult_engine (PROB_W=4, N=8); expected
// counts come from hand-stepping the two LFSRs over the first eight states.
module tb_sc_mult_engine;
   import sc_pkg::*;

   localparam int PROB_W   = 4;
   localparam int LEN_LOG2 = 3;
   localparam int N        = 8;
   localparam int LAT      = N + 3;
   localparam int WIN      = 2 * LAT + 6;
`ifdef SC_SCALED_ADD_EN
   localparam int EXP_ADD  = 4;
`else
   localparam int EXP_ADD  = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sc_mult_engine_if #(.PROB_W(PROB_W), .LEN_LOG2(LEN_LOG2)) bus ();

   sc_mult_engine #(.PROB_W(PROB_W), .LEN_LOG2(LEN_LOG2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [LEN_LOG2:0] r1, r2, clean_r;
   int lat1, lat2, n_done, n_ones;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One request; optional start+operand disturbance, reset pulse, or chained restart on done.
   task automatic run(input logic [1:0] m, input logic [PROB_W-1:0] pa, input logic [PROB_W-1:0] pb,
                      input int dist_c, input int rst_c, input bit chain);
      int c0;
      r1 = '0; r2 = '0; lat1 = -1; lat2 = -1; n_done = 0; n_ones = 0; c0 = 0;
      @(negedge clk);
      bus.mode = m; bus.prob_a = pa; bus.prob_b = pb; bus.start = 1'b1;
      for (int c = 0; c < WIN; c++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         if (bus.sn_out) n_ones++;
         if (bus.done) begin
            n_done++;
            if (n_done == 1) begin
               lat1 = c;
               r1   = bus.result;
               if (chain) begin
                  bus.start = 1'b1;
                  c0 = c + 1;
               end
            end else begin
               lat2 = c - c0;
               r2   = bus.result;
            end
         end
         if (c == dist_c) begin
            bus.start = 1'b1;
            bus.mode = ~m; bus.prob_a = ~pa; bus.prob_b = ~pb;
         end
         if (c == rst_c) begin
            rst_n = 1'b0;
            #1;
            check_eq("rst_mid_busy", bus.busy, 0);
            check_eq("rst_mid_result", bus.result, 0);
            check_eq("rst_mid_sn_out", bus.sn_out, 0);
            check_eq("rst_mid_done", bus.done, 0);
         end
         if (c == rst_c + 1) rst_n = 1'b1;
      end
   endtask

   logic [1:0]        v_mode [9] = '{MODE_AND, MODE_XNOR, MODE_AND, MODE_AND, MODE_XNOR,
                                     MODE_XNOR, MODE_ADD, MODE_ADD, 2'b11};
   logic [PROB_W-1:0] v_pa   [9] = '{4'd0, 4'd0, 4'd15, 4'd1, 4'd0, 4'd15, 4'd0, 4'd15, 4'd15};
   logic [PROB_W-1:0] v_pb   [9] = '{4'd15, 4'd0, 4'd15, 4'd8, 4'd8, 4'd15, 4'd0, 4'd0, 4'd0};
   int                v_exp  [9] = '{0, 8, 7, 2, 6, 7, 0, EXP_ADD, EXP_ADD};

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0; bus.mode = 2'b00; bus.prob_a = '0; bus.prob_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_busy", bus.busy, 0);
      check_eq("reset_done", bus.done, 0);
      check_eq("reset_result", bus.result, 0);
      check_eq("reset_sn_out", bus.sn_out, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run(v_mode[i], v_pa[i], v_pb[i], -1, -1, 1'b0);
         check_eq($sformatf("v%0d_result", i), r1, v_exp[i]);
         check_eq($sformatf("v%0d_latency", i), lat1, LAT);
         check_eq($sformatf("v%0d_done_count", i), n_done, 1);
         check_eq($sformatf("v%0d_sn_ones", i), n_ones, v_exp[i]);
         check_eq($sformatf("v%0d_idle_busy", i), bus.busy, 0);
      end

      // Mid-run start and operand changes must not disturb the run.
      run(MODE_AND, 4'd15, 4'd15, 4, -1, 1'b0);
      check_eq("dist_result", r1, 7);
      check_eq("dist_done_count", n_done, 1);
      check_eq("dist_latency", lat1, LAT);
      run(MODE_AND, 4'd15, 4'd15, -1, -1, 1'b0);
      clean_r = r1;
      check_eq("dist_vs_clean", clean_r, 7);

      // Back-to-back with the second start presented in the done cycle.
      run(MODE_XNOR, 4'd0, 4'd8, -1, -1, 1'b1);
      check_eq("b2b_done_count", n_done, 2);
      check_eq("b2b_result1", r1, 6);
      check_eq("b2b_result2", r2, 6);
      check_eq("b2b_latency1", lat1, LAT);
      check_eq("b2b_latency2", lat2, LAT);

      // Reset during RUN after a run leaving a nonzero result.
      run(MODE_XNOR, 4'd0, 4'd0, -1, -1, 1'b0);
      check_eq("pre_rst_result", r1, 8);
      run(MODE_XNOR, 4'd0, 4'd0, -1, 5, 1'b0);
      check_eq("rst_run_done_count", n_done, 0);
      check_eq("rst_run_result_after", bus.result, 0);
      run(MODE_XNOR, 4'd0, 4'd0, -1, -1, 1'b0);
      check_eq("post_rst_result", r1, 8);
      check_eq("post_rst_latency", lat1, LAT);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
